// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN activation bit packer.
// Word width, default kernel pack length and packer state encoding.
package bnn_pkg;

    localparam int BNN_WORD_W          = 32;
    localparam int BNN_DEF_MATRIX_SIZE = 9;

    typedef enum logic {
        PK_FILL = 1'b0,
        PK_HOLD = 1'b1
    } pack_state_e;

    // Out-of-range requests (0 or above a full word) fall back to a full word.
    function automatic logic [5:0] len_clamp(input logic [5:0] req);
        if (req == 6'd0 || req > 6'd32) begin
            return 6'd32;
        end
        return req;
    endfunction

endpackage

// File: rtl/bnn_pack.sv
// Serial-to-parallel packer for thresholded BNN activation bits.
// Collects pack_len bits LSB-first, then holds the word until consumed.
module bnn_pack
    import bnn_pkg::*;
#(
    parameter int WORD_W  = BNN_WORD_W,
    parameter int DEF_LEN = BNN_DEF_MATRIX_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              len_WE,
    input  logic [5:0]        len_in,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              flush,
    input  logic              word_ready,
    output logic              bit_ready,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_out,
    output logic [5:0]        word_len,
    output logic              cfg_err
);

    pack_state_e       state_q, state_d;
    logic [5:0]        count_q, count_d;
    logic [5:0]        len_q, len_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [5:0]        wlen_q, wlen_d;
    logic              err_q, err_d;

    logic              acc;
    logic [5:0]        cnt_inc;
    logic [WORD_W-1:0] word_acc;

    assign acc     = bit_valid & (state_q == PK_FILL);
    assign cnt_inc = count_q + {5'd0, acc};

    // Merge the accepted bit into the partial word at the current position.
    always_comb begin
        word_acc = word_q;
        if (acc) begin
            word_acc[count_q[4:0]] = bit_in;
        end
    end

    // Next-state: fill/complete/flush in FILL, wait for consumer in HOLD.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        word_d  = word_q;
        wlen_d  = wlen_q;
        err_d   = err_q;
        unique case (state_q)
            PK_FILL: begin
                word_d  = word_acc;
                count_d = cnt_inc;
                if (len_WE) begin
                    if (count_q == 6'd0) begin
                        len_d = len_clamp(len_in);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // The current bit is judged against the length in force
                // before any same-cycle length write.
                if ((acc && cnt_inc >= len_q) ||
                    (flush && cnt_inc != 6'd0)) begin
                    state_d = PK_HOLD;
                    wlen_d  = cnt_inc;
                    count_d = 6'd0;
                end
            end
            PK_HOLD: begin
                if (len_WE) begin
                    err_d = 1'b1;
                end
                if (word_ready) begin
                    state_d = PK_FILL;
                    word_d  = '0;
                    wlen_d  = 6'd0;
                end
            end
            default: begin
                state_d = PK_FILL;
            end
        endcase
    end

    // State registers; reset discards any partial or held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PK_FILL;
            count_q <= 6'd0;
            len_q   <= 6'(DEF_LEN);
            word_q  <= '0;
            wlen_q  <= 6'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            word_q  <= word_d;
            wlen_q  <= wlen_d;
            err_q   <= err_d;
        end
    end

    assign bit_ready  = (state_q == PK_FILL);
    assign word_valid = (state_q == PK_HOLD);
    assign word_out   = word_q;
    assign word_len   = wlen_q;
    assign cfg_err    = err_q;

endmodule
